// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit, decoder and memory control:
// default widths, halt opcode, opcode field position and FSM state encoding.
package fetch_unit_pkg;

    localparam int          PKG_PC_W    = 8;
    localparam logic [3:0]  PKG_HALT_OP = 4'b1111;
    localparam int          OP_MSB      = 27;
    localparam int          OP_LSB      = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: load a redirect target or step by one,
// wrapping modulo 2^PC_W.
module fetch_pc #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    // PC register; load has priority over increment
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests a word at pc, holds it in the instruction
// register until retired, then advances or redirects pc; stops on HALT_OP.
module fetch_unit #(
    parameter int         PC_W    = fetch_unit_pkg::PKG_PC_W,
    parameter logic [3:0] HALT_OP = fetch_unit_pkg::PKG_HALT_OP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [7:0]      retire_count
);
    import fetch_unit_pkg::*;

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic         capture_s;
    logic         retire_s;
    logic         pc_load_s;
    logic         pc_inc_s;

    fetch_pc #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load_s),
        .inc    (pc_inc_s),
        .target (branch_target),
        .pc     (pc)
    );

    assign mem_req  = (state_r == ST_FETCH) || (state_r == ST_WAIT);
    assign mem_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; branch inputs matter only on the retire cycle
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        retire_s     = 1'b0;
        pc_load_s    = 1'b0;
        pc_inc_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                if (mem_ready) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    retire_s = 1'b1;
                    if (opcode_of(instr) == HALT_OP) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                        pc_load_s    = branch_taken;
                        pc_inc_s     = !branch_taken;
                    end
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Instruction register, status flags and saturating retire counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr        <= 32'h0000_0000;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            retire_count <= 8'd0;
        end else begin
            if (capture_s) begin
                instr <= mem_rdata;
            end else begin
                instr <= instr;
            end
            instr_valid <= (state_next_s == ST_ISSUE);
            halted      <= (state_next_s == ST_HALT);
            if (retire_s && (retire_count != 8'hFF)) begin
                retire_count <= retire_count + 8'd1;
            end else begin
                retire_count <= retire_count;
            end
        end
    end

endmodule
